// File: rtl/axi_slave_sram.sv
// AXI4 slave memory model: AW/W/B and AR/R terminate into a word array.
// One write burst and one read burst in flight, each with its own FSM.
module axi_slave_sram #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS      = 1024,
  parameter int RD_LAT         = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_ID_WIDTH-1:0]       axi_aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr_i,
  input  logic [7:0]                    axi_aw_len_i,
  input  logic [1:0]                    axi_aw_burst_i,
  input  logic                          axi_aw_valid_i,
  output logic                          axi_aw_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]     axi_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0]   axi_w_strb_i,
  input  logic                          axi_w_last_i,
  input  logic                          axi_w_valid_i,
  output logic                          axi_w_ready_o,
  output logic [AXI_ID_WIDTH-1:0]       axi_b_id_o,
  output logic [1:0]                    axi_b_resp_o,
  output logic                          axi_b_valid_o,
  input  logic                          axi_b_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]       axi_ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_ar_addr_i,
  input  logic [7:0]                    axi_ar_len_i,
  input  logic [1:0]                    axi_ar_burst_i,
  input  logic                          axi_ar_valid_i,
  output logic                          axi_ar_ready_o,
  output logic [AXI_ID_WIDTH-1:0]       axi_r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]     axi_r_data_o,
  output logic [1:0]                    axi_r_resp_o,
  output logic                          axi_r_last_o,
  output logic                          axi_r_valid_o,
  input  logic                          axi_r_ready_i
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int OFS   = $clog2(BYTES);
  localparam int IDXW  = AXI_ADDR_WIDTH - OFS;
  localparam int MIW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int LATW  = 4;
  localparam logic [LATW-1:0] LAT_LOAD = LATW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  // Reserved burst type and WRAP with an illegal length both error and step as INCR.
  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'b11) ||
           ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                  (len == 8'd7) || (len == 8'd15)));
  endfunction

  function automatic logic [AXI_ADDR_WIDTH-1:0] step_addr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [7:0]                len,
    input logic [1:0]                burst
  );
    logic [AXI_ADDR_WIDTH-1:0] inc;
    logic [AXI_ADDR_WIDTH-1:0] len_ext;
    logic [AXI_ADDR_WIDTH-1:0] mask;
    inc     = addr + AXI_ADDR_WIDTH'(BYTES);
    len_ext = {{(AXI_ADDR_WIDTH-8){1'b0}}, len};
    mask    = ((len_ext + AXI_ADDR_WIDTH'(1)) << OFS) - AXI_ADDR_WIDTH'(1);
    if (burst == 2'b00)
      return addr;
    else if ((burst == 2'b10) && !burst_err(burst, len))
      return (addr & ~mask) | (inc & mask);
    else
      return inc;
  endfunction

  function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return addr[AXI_ADDR_WIDTH-1:OFS] >= IDXW'(MEM_WORDS);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // ---------------- write path ----------------
  w_state_t                  w_state_q;
  logic                      aw_ready_q;
  logic                      w_ready_q;
  logic                      b_valid_q;
  logic [AXI_ID_WIDTH-1:0]   b_id_q;
  logic [1:0]                b_resp_q;
  logic [AXI_ID_WIDTH-1:0]   w_id_q;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]                w_len_q;
  logic [1:0]                w_burst_q;
  logic [7:0]                w_cnt_q;
  logic                      w_err_q;

  logic                      w_fire;
  logic                      w_last_beat;
  logic                      w_oor;
  logic                      w_beat_err;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_d;

  assign w_fire      = w_ready_q && axi_w_valid_i;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_oor       = out_of_range(w_addr_q);
  assign w_beat_err  = w_oor || (axi_w_last_i != w_last_beat);
  assign w_addr_d    = step_addr(w_addr_q, w_len_q, w_burst_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= RESP_OKAY;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_burst_q  <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_ready_q && axi_aw_valid_i) begin
            w_id_q     <= axi_aw_id_i;
            w_addr_q   <= axi_aw_addr_i;
            w_len_q    <= axi_aw_len_i;
            w_burst_q  <= axi_aw_burst_i;
            w_cnt_q    <= '0;
            w_err_q    <= burst_err(axi_aw_burst_i, axi_aw_len_i);
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            w_state_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr_q <= w_addr_d;
            w_cnt_q  <= w_cnt_q + 8'd1;
            w_err_q  <= w_err_q || w_beat_err;
            // The beat count, not w_last, closes the burst.
            if (w_last_beat) begin
              w_ready_q <= 1'b0;
              b_valid_q <= 1'b1;
              b_id_q    <= w_id_q;
              b_resp_q  <= (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_b_ready_i) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_state_q  <= W_IDLE;
          end
        end
        default: begin
          aw_ready_q <= 1'b1;
          w_ready_q  <= 1'b0;
          b_valid_q  <= 1'b0;
          w_state_q  <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && !w_oor) begin
      for (int b = 0; b < BYTES; b++) begin
        if (axi_w_strb_i[b])
          mem_q[w_addr_q[OFS +: MIW]][8*b +: 8] <= axi_w_data_i[8*b +: 8];
      end
    end
  end

  assign axi_aw_ready_o = aw_ready_q;
  assign axi_w_ready_o  = w_ready_q;
  assign axi_b_valid_o  = b_valid_q;
  assign axi_b_id_o     = b_id_q;
  assign axi_b_resp_o   = b_resp_q;

  // ---------------- read path ----------------
  r_state_t                  r_state_q;
  logic                      ar_ready_q;
  logic                      r_valid_q;
  logic                      r_last_q;
  logic [AXI_ID_WIDTH-1:0]   r_id_q;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]                r_len_q;
  logic [1:0]                r_burst_q;
  logic [7:0]                r_cnt_q;
  logic                      r_berr_q;
  logic [LATW-1:0]           r_lat_q;

  logic                      r_oor;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_d;
  logic [7:0]                r_cnt_d;

  assign r_oor    = out_of_range(r_addr_q);
  assign r_addr_d = step_addr(r_addr_q, r_len_q, r_burst_q);
  assign r_cnt_d  = r_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_burst_q  <= '0;
      r_cnt_q    <= '0;
      r_berr_q   <= 1'b0;
      r_lat_q    <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_ready_q && axi_ar_valid_i) begin
            r_id_q     <= axi_ar_id_i;
            r_addr_q   <= axi_ar_addr_i;
            r_len_q    <= axi_ar_len_i;
            r_burst_q  <= axi_ar_burst_i;
            r_cnt_q    <= '0;
            r_berr_q   <= burst_err(axi_ar_burst_i, axi_ar_len_i);
            ar_ready_q <= 1'b0;
            if (RD_LAT == 0) begin
              r_valid_q <= 1'b1;
              r_last_q  <= (axi_ar_len_i == 8'd0);
              r_state_q <= R_DATA;
            end else begin
              r_lat_q   <= LAT_LOAD;
              r_state_q <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_lat_q == '0) begin
            r_valid_q <= 1'b1;
            r_last_q  <= (r_len_q == 8'd0);
            r_state_q <= R_DATA;
          end else begin
            r_lat_q <= r_lat_q - LATW'(1);
          end
        end
        R_DATA: begin
          if (axi_r_ready_i) begin
            if (r_last_q) begin
              r_valid_q  <= 1'b0;
              r_last_q   <= 1'b0;
              ar_ready_q <= 1'b1;
              r_state_q  <= R_IDLE;
            end else begin
              r_addr_q <= r_addr_d;
              r_cnt_q  <= r_cnt_d;
              r_last_q <= (r_cnt_d == r_len_q);
            end
          end
        end
        default: begin
          ar_ready_q <= 1'b1;
          r_valid_q  <= 1'b0;
          r_last_q   <= 1'b0;
          r_state_q  <= R_IDLE;
        end
      endcase
    end
  end

  // Read data is taken straight from the array, so a same-cycle write shows the old word.
  assign axi_r_data_o   = (r_valid_q && !r_oor) ? mem_q[r_addr_q[OFS +: MIW]] : '0;
  assign axi_r_resp_o   = (r_valid_q && (r_berr_q || r_oor)) ? RESP_SLVERR : RESP_OKAY;
  assign axi_ar_ready_o = ar_ready_q;
  assign axi_r_valid_o  = r_valid_q;
  assign axi_r_last_o   = r_last_q;
  assign axi_r_id_o     = r_id_q;

endmodule
